// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pkg
// Description : Shared SHA-256 definitions for the votechain hashing core.
//               Message-schedule sigma functions (sig0/sig1), compression
//               Sigma functions (bsig0/bsig1), block-size constants and the
//               message-schedule state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

  localparam int N_MSG_WORDS = 16;
  localparam int N_ROUNDS    = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DONE   = 2'd3
  } w_state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message schedule: small sigma 0
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  // Message schedule: small sigma 1
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Compression: big Sigma 0
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  // Compression: big Sigma 1
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

endpackage
`default_nettype wire

// File: rtl/w_sched.sv
`default_nettype none
// ============================================================================
// Module      : w_sched
// Description : SHA-256 message-schedule expander. Loads a 16-word block
//               into the external w_ram, then computes W[16..63] using the
//               four w_ram read ports, streaming every W[t] in index order.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               start                      - begin a block (IDLE only)
//               msg_valid/msg_word/msg_ready - message word handshake
//               ram_we/ram_addr_W/ram_data_in - w_ram write port (flopped)
//               ram_addr_R1..R4            - read addresses t-2,t-7,t-15,t-16
//               ram_data_out1..4           - read data, one cycle latency
//               w_valid/w_data/w_idx       - W[t] stream to compressor
//               busy, done                 - status
// Revision    : 1.0 - initial release
// ============================================================================
module w_sched
  import sha256_pkg::*;
#(
  parameter int BW       = 31,
  parameter int wAddr_BW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              msg_valid,
  input  logic [BW:0]       msg_word,
  output logic              msg_ready,
  output logic              ram_we,
  output logic [wAddr_BW:0] ram_addr_W,
  output logic [BW:0]       ram_data_in,
  output logic [wAddr_BW:0] ram_addr_R1,
  output logic [wAddr_BW:0] ram_addr_R2,
  output logic [wAddr_BW:0] ram_addr_R3,
  output logic [wAddr_BW:0] ram_addr_R4,
  input  logic [BW:0]       ram_data_out1,
  input  logic [BW:0]       ram_data_out2,
  input  logic [BW:0]       ram_data_out3,
  input  logic [BW:0]       ram_data_out4,
  output logic              w_valid,
  output logic [BW:0]       w_data,
  output logic [wAddr_BW:0] w_idx,
  output logic              busy,
  output logic              done
);

  localparam int AW = wAddr_BW + 1;

  localparam logic [1:0] c_IDLE   = ST_IDLE;
  localparam logic [1:0] c_LOAD   = ST_LOAD;
  localparam logic [1:0] c_EXPAND = ST_EXPAND;
  localparam logic [1:0] c_DONE   = ST_DONE;

  localparam logic [wAddr_BW:0] c_LOAD_LAST = AW'(N_MSG_WORDS - 1);
  localparam logic [wAddr_BW:0] c_T_FIRST   = AW'(N_MSG_WORDS);
  localparam logic [wAddr_BW:0] c_T_LAST    = AW'(N_ROUNDS - 1);
  localparam logic [wAddr_BW:0] c_D1        = AW'(2);
  localparam logic [wAddr_BW:0] c_D2        = AW'(7);
  localparam logic [wAddr_BW:0] c_D3        = AW'(15);
  localparam logic [wAddr_BW:0] c_D4        = AW'(16);

  logic [1:0]        r_state;
  logic [wAddr_BW:0] r_cnt;      // LOAD word count
  logic [wAddr_BW:0] r_t;        // index whose addresses are currently driven
  logic              r_iss;      // current addresses are a live issue
  logic              r_rd_vld;   // read data on ram_data_out* is live
  logic [wAddr_BW:0] r_rd_t;     // index matching the live read data
  logic              r_we;
  logic [wAddr_BW:0] r_addr_w;
  logic [BW:0]       r_data;
  logic [wAddr_BW:0] r_r1, r_r2, r_r3, r_r4;

  logic [wAddr_BW:0] w_t_next;
  logic [BW:0]       w_sum;

  // The first issue (t=16) is launched on the edge that accepts word 15, so
  // the addresses are already on the bus in the first EXPAND cycle.
  assign w_t_next = (r_state == c_LOAD) ? c_T_FIRST : r_t + AW'(1);

  // Carries beyond bit 31 are discarded by the 32-bit sum width.
  assign w_sum = sig1(ram_data_out1) + ram_data_out2 + sig0(ram_data_out3) + ram_data_out4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_cnt    <= '0;
      r_t      <= '0;
      r_iss    <= 1'b0;
      r_rd_vld <= 1'b0;
      r_rd_t   <= '0;
      r_we     <= 1'b0;
      r_addr_w <= '0;
      r_data   <= '0;
      r_r1     <= '0;
      r_r2     <= '0;
      r_r3     <= '0;
      r_r4     <= '0;
    end else begin
      r_we     <= 1'b0;
      r_rd_vld <= r_iss;
      r_rd_t   <= r_t;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_state <= c_LOAD;
            r_cnt   <= '0;
          end
        end
        c_LOAD: begin
          if (msg_valid) begin
            r_we     <= 1'b1;
            r_addr_w <= r_cnt;
            r_data   <= msg_word;
            r_cnt    <= r_cnt + AW'(1);
            if (r_cnt == c_LOAD_LAST) begin
              r_state <= c_EXPAND;
              r_t     <= w_t_next;
              r_iss   <= 1'b1;
              r_r1    <= w_t_next - c_D1;
              r_r2    <= w_t_next - c_D2;
              r_r3    <= w_t_next - c_D3;
              r_r4    <= w_t_next - c_D4;
            end
          end
        end
        c_EXPAND: begin
          // Issue side: addresses hold at t=63 once issuing stops.
          if (r_iss) begin
            if (r_t == c_T_LAST) begin
              r_iss <= 1'b0;
            end else begin
              r_t  <= w_t_next;
              r_r1 <= w_t_next - c_D1;
              r_r2 <= w_t_next - c_D2;
              r_r3 <= w_t_next - c_D3;
              r_r4 <= w_t_next - c_D4;
            end
          end
          // Write side: two cycles behind the issue.
          if (r_rd_vld) begin
            r_we     <= 1'b1;
            r_addr_w <= r_rd_t;
            r_data   <= w_sum;
          end
          if (r_we && (r_addr_w == c_T_LAST)) begin
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign msg_ready   = (r_state == c_LOAD);
  assign busy        = (r_state != c_IDLE);
  assign done        = (r_state == c_DONE);
  assign ram_we      = r_we;
  assign ram_addr_W  = r_addr_w;
  assign ram_data_in = r_data;
  assign w_valid     = r_we;
  assign w_idx       = r_addr_w;
  assign w_data      = r_data;
  assign ram_addr_R1 = r_r1;
  assign ram_addr_R2 = r_r2;
  assign ram_addr_R3 = r_r3;
  assign ram_addr_R4 = r_r4;

endmodule
`default_nettype wire

// File: tb/tb_w_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_w_sched
// Description : Self-checking bench for w_sched with a behavioural w_ram,
//               a queue-based scoreboard and a plain-arithmetic SHA-256
//               message-schedule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_w_sched;

  localparam int K_RAND = 0;
  localparam int K_ABC  = 1;
  localparam int K_ONES = 2;

  localparam int M_CONT   = 0;
  localparam int M_TOGGLE = 1;
  localparam int M_RANDOM = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        msg_valid = 1'b0;
  logic [31:0] msg_word = '0;
  logic        msg_ready;
  logic        ram_we;
  logic [5:0]  ram_addr_W;
  logic [31:0] ram_data_in;
  logic [5:0]  ram_addr_R1, ram_addr_R2, ram_addr_R3, ram_addr_R4;
  logic [31:0] ram_data_out1, ram_data_out2, ram_data_out3, ram_data_out4;
  logic        w_valid;
  logic [31:0] w_data;
  logic [5:0]  w_idx;
  logic        busy;
  logic        done;

  w_sched #(.BW(31), .wAddr_BW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .msg_valid(msg_valid), .msg_word(msg_word), .msg_ready(msg_ready),
    .ram_we(ram_we), .ram_addr_W(ram_addr_W), .ram_data_in(ram_data_in),
    .ram_addr_R1(ram_addr_R1), .ram_addr_R2(ram_addr_R2),
    .ram_addr_R3(ram_addr_R3), .ram_addr_R4(ram_addr_R4),
    .ram_data_out1(ram_data_out1), .ram_data_out2(ram_data_out2),
    .ram_data_out3(ram_data_out3), .ram_data_out4(ram_data_out4),
    .w_valid(w_valid), .w_data(w_data), .w_idx(w_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // w_ram: registered read address, array read after the same-edge write.
  logic [31:0] mem [64];
  logic [5:0]  aq1, aq2, aq3, aq4;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_W] <= ram_data_in;
    aq1 <= ram_addr_R1;
    aq2 <= ram_addr_R2;
    aq3 <= ram_addr_R3;
    aq4 <= ram_addr_R4;
  end
  assign ram_data_out1 = mem[aq1];
  assign ram_data_out2 = mem[aq2];
  assign ram_data_out3 = mem[aq3];
  assign ram_data_out4 = mem[aq4];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int start_cyc = 0;
  int n_done = 0;
  int exp_done = 0;
  bit chk_lat = 1'b0;
  bit prev_done = 1'b0;

  logic [5:0]  q_idx [$];
  logic [31:0] q_dat [$];
  logic [31:0] msg [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_expected(input int kind);
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) w[i] = msg[i];
    for (int i = 16; i < 64; i++)
      w[i] = ss1(w[i-2]) + w[i-7] + ss0(w[i-15]) + w[i-16];
    // Published golden values take precedence for the known vectors.
    if (kind == K_ABC) begin
      w[16] = 32'h61626380;
      w[17] = 32'h000F0000;
    end
    if (kind == K_ONES) w[16] = 32'h203FFFFC;
    for (int i = 0; i < 64; i++) begin
      q_idx.push_back(6'(i));
      q_dat.push_back(w[i]);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("we_eq_valid", 32'(ram_we), 32'(w_valid));
      chk("addrW_eq_idx", 32'(ram_addr_W), 32'(w_idx));
      chk("din_eq_wdata", ram_data_in, w_data);
      if (w_valid) begin
        if (q_idx.size() == 0) begin
          chk("unexpected_w_valid_idx", 32'(w_idx), 32'hFFFF_FFFF);
        end else begin
          logic [5:0]  ei;
          logic [31:0] ed;
          ei = q_idx.pop_front();
          ed = q_dat.pop_front();
          chk("w_idx", 32'(w_idx), 32'(ei));
          chk("w_data", w_data, ed);
        end
      end
      if (start && !busy) start_cyc = cyc;
      if (done) begin
        n_done++;
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("stream_drained_at_done", 32'(q_idx.size()), 32'd0);
        chk("done_single_pulse", 32'(prev_done), 32'd0);
        if (chk_lat) chk("done_latency", 32'(cyc - start_cyc), 32'd67);
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_msg_ready"}, 32'(msg_ready), 0);
    chk({tag, "_ram_we"}, 32'(ram_we), 0);
    chk({tag, "_ram_addr_W"}, 32'(ram_addr_W), 0);
    chk({tag, "_ram_data_in"}, ram_data_in, 0);
    chk({tag, "_R1"}, 32'(ram_addr_R1), 0);
    chk({tag, "_R2"}, 32'(ram_addr_R2), 0);
    chk({tag, "_R3"}, 32'(ram_addr_R3), 0);
    chk({tag, "_R4"}, 32'(ram_addr_R4), 0);
    chk({tag, "_w_valid"}, 32'(w_valid), 0);
    chk({tag, "_w_data"}, w_data, 0);
    chk({tag, "_w_idx"}, 32'(w_idx), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  task automatic set_rand();
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
  endtask

  // Called at posedge+#1 with the DUT idle or about to go idle.
  task automatic run_block(input int kind, input int mode);
    int k = 0;
    int guard = 0;
    bit v = 1'b0;
    bit acc;
    wait_idle();
    push_expected(kind);
    exp_done++;
    chk_lat = (mode == M_CONT);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (k < 16 && guard < 300) begin
      case (mode)
        M_CONT:   v = 1'b1;
        M_TOGGLE: v = !v;
        default:  v = 1'($urandom_range(0, 1));
      endcase
      chk("msg_ready_in_load", 32'(msg_ready), 32'd1);
      msg_valid = v;
      msg_word  = v ? msg[k] : $urandom;
      acc = v && msg_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) k++;
    end
    msg_valid = 1'b0;
    msg_word  = $urandom;
    chk("words_accepted", 32'(k), 32'd16);
    chk("msg_ready_after_load", 32'(msg_ready), 32'd0);
    chk("busy_after_load", 32'(busy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "abc" padded block, continuous valid
    set_abc();
    run_block(K_ABC, M_CONT);

    // all-ones block: modular wrap
    for (int i = 0; i < 16; i++) msg[i] = 32'hFFFF_FFFF;
    run_block(K_ONES, M_CONT);

    // msg_valid toggling every cycle in LOAD
    set_rand();
    run_block(K_RAND, M_TOGGLE);

    // start pulsed mid-EXPAND, msg_valid driven outside LOAD
    set_rand();
    run_block(K_RAND, M_CONT);
    repeat (20) begin @(posedge clk); #1; end
    start = 1'b1; msg_valid = 1'b1; msg_word = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    msg_valid = 1'b0;

    // asynchronous reset at EXPAND t=30
    set_rand();
    run_block(K_RAND, M_CONT);
    begin
      int n = 0;
      while (!(busy && ram_addr_R1 == 6'd28) && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk("reached_t30", 32'(ram_addr_R1), 32'd28);
    end
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    q_idx.delete();
    q_dat.delete();
    exp_done--;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_abc();
    run_block(K_ABC, M_CONT);

    // back-to-back blocks: second start in the cycle after busy falls
    set_rand();
    run_block(K_RAND, M_CONT);
    set_rand();
    run_block(K_RAND, M_CONT);

    // random gaps
    for (int b = 0; b < 3; b++) begin
      set_rand();
      run_block(K_RAND, M_RANDOM);
    end

    wait_idle();
    repeat (5) begin @(posedge clk); #1; end
    chk("done_count", 32'(n_done), 32'(exp_done));
    chk("scoreboard_empty", 32'(q_idx.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
